// File: rtl/cpu_isa_pkg.sv
// rtl/cpu_isa_pkg.sv - ISA constants and D/X payload type shared by the decode/execute pipeline
package cpu_isa_pkg;

  localparam int XLEN  = 32;
  localparam int REG_W = 5;

  // Low bit of each 5-bit instruction field
  localparam int OPC_LO = 27;
  localparam int RD_LO  = 22;
  localparam int RS_LO  = 17;
  localparam int RT_LO  = 12;

  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] OP_BNE   = 5'b00010;
  localparam logic [4:0] OP_JR    = 5'b00100;
  localparam logic [4:0] OP_ADDI  = 5'b00101;
  localparam logic [4:0] OP_BLT   = 5'b00110;
  localparam logic [4:0] OP_SW    = 5'b00111;
  localparam logic [4:0] OP_LW    = 5'b01000;
  localparam logic [4:0] OP_SETX  = 5'b10101;
  localparam logic [4:0] OP_BEX   = 5'b10110;

  localparam logic [REG_W-1:0] REG_ZERO   = 5'd0;
  localparam logic [REG_W-1:0] REG_STATUS = 5'd30;

  typedef struct packed {
    logic [XLEN-1:0] insn;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
  } dx_payload_t;

endpackage

// File: rtl/dx_read_decode.sv
// rtl/dx_read_decode.sv - maps an instruction's register fields to the two register file read ports
// Only bits [31:12] carry register information, so only they are brought in.
module dx_read_decode
  import cpu_isa_pkg::*;
(
  input  logic [XLEN-1:RT_LO] insn_i,
  output logic [REG_W-1:0]    read_a_o,
  output logic [REG_W-1:0]    read_b_o,
  output logic                used_a_o,
  output logic                used_b_o
);

  logic [4:0]       opcode;
  logic [REG_W-1:0] rd, rs, rt;

  assign opcode = insn_i[OPC_LO +: 5];
  assign rd     = insn_i[RD_LO +: REG_W];
  assign rs     = insn_i[RS_LO +: REG_W];
  assign rt     = insn_i[RT_LO +: REG_W];

  always_comb begin
    read_a_o = (opcode == OP_BEX) ? REG_STATUS : rs;
    read_b_o = REG_ZERO;
    case (opcode)
      OP_RTYPE:                      read_b_o = rt;
      OP_SW, OP_BNE, OP_BLT, OP_JR:  read_b_o = rd;
      default:                       read_b_o = REG_ZERO;
    endcase
  end

  // r0 is hardwired zero, so a port addressing it never bypasses or hazards
  assign used_a_o = (read_a_o != REG_ZERO);
  assign used_b_o = (read_b_o != REG_ZERO);

endmodule

// File: rtl/dx_operand_stage.sv
// rtl/dx_operand_stage.sv - decode-to-execute operand stage: read decode, writeback bypass, load-use bubble, D/X register
// DX_WB_BYPASS_EN selects write-through bypass; without it a writeback address match stalls one cycle.
module dx_operand_stage
  import cpu_isa_pkg::*;
(
  input  logic             clock,
  input  logic             ctrl_reset,
  input  logic             flush,
  input  logic             fd_valid,
  output logic             fd_ready,
  input  logic [XLEN-1:0]  fd_insn,
  input  logic [XLEN-1:0]  fd_pc,
  output logic [REG_W-1:0] ctrl_readRegA,
  output logic [REG_W-1:0] ctrl_readRegB,
  input  logic [XLEN-1:0]  data_readRegA,
  input  logic [XLEN-1:0]  data_readRegB,
  input  logic             wb_we,
  input  logic [REG_W-1:0] wb_reg,
  input  logic [XLEN-1:0]  wb_data,
  output logic             dx_valid,
  input  logic             dx_ready,
  output logic [XLEN-1:0]  dx_insn,
  output logic [XLEN-1:0]  dx_pc,
  output logic [XLEN-1:0]  dx_opA,
  output logic [XLEN-1:0]  dx_opB
);

  logic [REG_W-1:0] addr_a, addr_b;
  logic             used_a, used_b;

  dx_read_decode u_decode (
    .insn_i   (fd_insn[XLEN-1:RT_LO]),
    .read_a_o (addr_a),
    .read_b_o (addr_b),
    .used_a_o (used_a),
    .used_b_o (used_b)
  );

  assign ctrl_readRegA = addr_a;
  assign ctrl_readRegB = addr_b;

  dx_payload_t      dx_q, dx_d;
  logic             dx_valid_q, dx_valid_d;
  logic             ld_pend_q, ld_pend_d;
  logic [REG_W-1:0] ld_reg_q, ld_reg_d;

  logic            wb_active, wb_hit_a, wb_hit_b;
  logic            wb_hazard, ld_hazard, hazard, adv;
  logic [XLEN-1:0] opnd_a, opnd_b;
  logic            is_lw;
  logic [REG_W-1:0] ld_rd;

  assign wb_active = wb_we && (wb_reg != REG_ZERO);
  assign wb_hit_a  = wb_active && used_a && (addr_a == wb_reg);
  assign wb_hit_b  = wb_active && used_b && (addr_b == wb_reg);

`ifdef DX_WB_BYPASS_EN
  assign opnd_a    = !used_a ? '0 : (wb_hit_a ? wb_data : data_readRegA);
  assign opnd_b    = !used_b ? '0 : (wb_hit_b ? wb_data : data_readRegB);
  assign wb_hazard = 1'b0;
`else
  // Without a bypass the register file is read again after the write lands
  assign opnd_a    = used_a ? data_readRegA : '0;
  assign opnd_b    = used_b ? data_readRegB : '0;
  assign wb_hazard = wb_hit_a || wb_hit_b;
`endif

  assign ld_hazard = ld_pend_q && ((used_a && (addr_a == ld_reg_q)) ||
                                   (used_b && (addr_b == ld_reg_q)));
  assign hazard    = ld_hazard || wb_hazard;
  assign adv       = !dx_valid_q || dx_ready;
  assign fd_ready  = fd_valid && adv && !hazard && !flush;

  assign is_lw = (fd_insn[OPC_LO +: 5] == OP_LW);
  assign ld_rd = fd_insn[RD_LO +: REG_W];

  always_comb begin
    dx_d       = dx_q;
    dx_valid_d = dx_valid_q;
    ld_pend_d  = ld_pend_q;
    ld_reg_d   = ld_reg_q;
    if (flush) begin
      dx_valid_d = 1'b0;
      ld_pend_d  = 1'b0;
    end else if (adv) begin
      dx_valid_d = fd_ready;
      ld_pend_d  = fd_ready && is_lw && (ld_rd != REG_ZERO);
      if (fd_ready) begin
        dx_d     = '{insn: fd_insn, pc: fd_pc, op_a: opnd_a, op_b: opnd_b};
        ld_reg_d = ld_rd;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      dx_q       <= '0;
      dx_valid_q <= 1'b0;
      ld_pend_q  <= 1'b0;
      ld_reg_q   <= REG_ZERO;
    end else begin
      dx_q       <= dx_d;
      dx_valid_q <= dx_valid_d;
      ld_pend_q  <= ld_pend_d;
      ld_reg_q   <= ld_reg_d;
    end
  end

  assign dx_valid = dx_valid_q;
  assign dx_insn  = dx_q.insn;
  assign dx_pc    = dx_q.pc;
  assign dx_opA   = dx_q.op_a;
  assign dx_opB   = dx_q.op_b;

endmodule

// File: tb/tb_dx_operand_stage.sv
// tb/tb_dx_operand_stage.sv - self-checking bench for dx_operand_stage (honours DX_WB_BYPASS_EN)
module tb_dx_operand_stage;

  logic        clock;
  logic        ctrl_reset, flush, fd_valid, fd_ready;
  logic [31:0] fd_insn, fd_pc, data_readRegA, data_readRegB;
  logic [4:0]  ctrl_readRegA, ctrl_readRegB;
  logic        wb_we;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        dx_valid, dx_ready;
  logic [31:0] dx_insn, dx_pc, dx_opA, dx_opB;

  int tests = 0;
  int fails = 0;

  dx_operand_stage dut (
    .clock(clock), .ctrl_reset(ctrl_reset), .flush(flush),
    .fd_valid(fd_valid), .fd_ready(fd_ready), .fd_insn(fd_insn), .fd_pc(fd_pc),
    .ctrl_readRegA(ctrl_readRegA), .ctrl_readRegB(ctrl_readRegB),
    .data_readRegA(data_readRegA), .data_readRegB(data_readRegB),
    .wb_we(wb_we), .wb_reg(wb_reg), .wb_data(wb_data),
    .dx_valid(dx_valid), .dx_ready(dx_ready),
    .dx_insn(dx_insn), .dx_pc(dx_pc), .dx_opA(dx_opA), .dx_opB(dx_opB)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Register file environment: r0 reads zero, writes land at the clock edge
  logic [31:0] rf [32];
  always @(posedge clock) if (wb_we && wb_reg != 5'd0) rf[wb_reg] <= wb_data;
  assign data_readRegA = (ctrl_readRegA == 5'd0) ? 32'd0 : rf[ctrl_readRegA];
  assign data_readRegB = (ctrl_readRegB == 5'd0) ? 32'd0 : rf[ctrl_readRegB];

  // Reference model of the stage
  logic        m_valid, m_ldpend;
  logic [4:0]  m_ldreg;
  logic [31:0] m_insn, m_pc, m_opA, m_opB;

  function automatic logic [4:0] m_addr_a(input logic [31:0] i);
    return (i[31:27] == 5'b10110) ? 5'd30 : i[21:17];
  endfunction

  function automatic logic [4:0] m_addr_b(input logic [31:0] i);
    case (i[31:27])
      5'b00000:                            return i[16:12];
      5'b00111, 5'b00010, 5'b00110, 5'b00100: return i[26:22];
      default:                             return 5'd0;
    endcase
  endfunction

  function automatic logic [31:0] m_opnd(input logic [4:0] addr);
    if (addr == 5'd0) return 32'd0;
`ifdef DX_WB_BYPASS_EN
    if (wb_we && wb_reg == addr) return wb_data;
`endif
    return rf[addr];
  endfunction

  function automatic logic m_hazard();
    logic [4:0] a, b;
    logic h;
    a = m_addr_a(fd_insn);
    b = m_addr_b(fd_insn);
    h = m_ldpend && ((a != 0 && a == m_ldreg) || (b != 0 && b == m_ldreg));
`ifndef DX_WB_BYPASS_EN
    h = h || (wb_we && wb_reg != 0 && ((a != 0 && a == wb_reg) || (b != 0 && b == wb_reg)));
`endif
    return h;
  endfunction

  function automatic logic m_ready();
    return fd_valid && (!m_valid || dx_ready) && !m_hazard() && !flush;
  endfunction

  always @(posedge clock) begin
    if (ctrl_reset) begin
      m_valid <= 0; m_ldpend <= 0; m_ldreg <= 0;
      m_insn <= 0; m_pc <= 0; m_opA <= 0; m_opB <= 0;
    end else if (flush) begin
      m_valid <= 0; m_ldpend <= 0;
    end else if (!m_valid || dx_ready) begin
      if (m_ready()) begin
        m_valid  <= 1;
        m_insn   <= fd_insn;
        m_pc     <= fd_pc;
        m_opA    <= m_opnd(m_addr_a(fd_insn));
        m_opB    <= m_opnd(m_addr_b(fd_insn));
        m_ldpend <= (fd_insn[31:27] == 5'b01000) && (fd_insn[26:22] != 5'd0);
        m_ldreg  <= fd_insn[26:22];
      end else begin
        m_valid  <= 0;
        m_ldpend <= 0;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [31:0] mk(input logic [4:0] op, rd, rs, rt);
    return {op, rd, rs, rt, 12'h123};
  endfunction

  task automatic present(input logic [31:0] insn, input logic [31:0] pc);
    fd_valid = 1'b1;
    fd_insn  = insn;
    fd_pc    = pc;
  endtask

  typedef struct {
    logic        fv;
    logic [31:0] insn;
    logic        we;
    logic [4:0]  wreg;
    logic [4:0]  ea, eb;
    logic        rdy_byp, rdy_nob;
  } vec_t;

  initial begin
    vec_t vt[15];
    logic [4:0] ops[10];
    logic [4:0] op, rd, rs, rt;
    logic exp_rdy;

    ctrl_reset = 1; flush = 0; fd_valid = 0; fd_insn = 0; fd_pc = 0;
    wb_we = 0; wb_reg = 0; wb_data = 0; dx_ready = 1;

    // Preload register file through the write port while in reset
    tick();
    for (int i = 1; i < 32; i++) begin
      wb_we = 1; wb_reg = 5'(i);
      wb_data = (i == 1) ? 32'd5 : (i == 2) ? 32'd7 : 32'h100 + 32'(i);
      tick();
    end
    wb_we = 0;
    tick();
    chk("reset_valid", dx_valid, 0);
    chk("reset_insn", dx_insn, 0);
    chk("reset_pc", dx_pc, 0);
    chk("reset_opA", dx_opA, 0);
    chk("reset_opB", dx_opB, 0);
    ctrl_reset = 0;
    tick();

    // add r3,r1,r2
    present(mk(5'b00000, 3, 1, 2), 32'h40);
    #1;
    chk("add_ready", fd_ready, 1);
    chk("add_rdA", ctrl_readRegA, 1);
    chk("add_rdB", ctrl_readRegB, 2);
    tick();
    chk("add_valid", dx_valid, 1);
    chk("add_opA", dx_opA, 5);
    chk("add_opB", dx_opB, 7);
    chk("add_pc", dx_pc, 32'h40);
    chk("add_insn", dx_insn, mk(5'b00000, 3, 1, 2));
    fd_valid = 0;
    tick();
    chk("idle_valid", dx_valid, 0);

    // Writeback to r1 in the decode cycle
    present(mk(5'b00000, 3, 1, 2), 32'h44);
    wb_we = 1; wb_reg = 1; wb_data = 32'hAA;
    #1;
`ifdef DX_WB_BYPASS_EN
    chk("byp_ready", fd_ready, 1);
    tick();
    wb_we = 0;
    chk("byp_valid", dx_valid, 1);
    chk("byp_opA", dx_opA, 32'hAA);
    chk("byp_opB", dx_opB, 7);
`else
    chk("nobyp_stall", fd_ready, 0);
    tick();
    wb_we = 0;
    chk("nobyp_bubble", dx_valid, 0);
    #1;
    chk("nobyp_ready", fd_ready, 1);
    tick();
    chk("nobyp_valid", dx_valid, 1);
    chk("nobyp_opA", dx_opA, 32'hAA);
`endif

    // Load-use: lw r4,0(r1); add r5,r4,r4; add r6,r0,r0
    present(mk(5'b01000, 4, 1, 0), 32'h48);
    #1;
    chk("lw_ready", fd_ready, 1);
    tick();
    chk("lw_valid", dx_valid, 1);
    present(mk(5'b00000, 5, 4, 4), 32'h4C);
    #1;
    chk("lu_stall", fd_ready, 0);
    tick();
    chk("lu_bubble", dx_valid, 0);
    #1;
    chk("lu_ready", fd_ready, 1);
    tick();
    chk("lu_valid", dx_valid, 1);
    chk("lu_insn", dx_insn, mk(5'b00000, 5, 4, 4));
    chk("lu_opA", dx_opA, 32'h104);
    present(mk(5'b00000, 6, 0, 0), 32'h50);
    #1;
    chk("r0_noharz", fd_ready, 1);
    tick();
    chk("r0_valid", dx_valid, 1);
    chk("r0_opA", dx_opA, 0);

    // Execute stall for three cycles
    dx_ready = 0;
    present(mk(5'b00000, 7, 1, 2), 32'h54);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("stall_ready", fd_ready, 0);
      tick();
      chk("stall_valid", dx_valid, 1);
      chk("stall_insn", dx_insn, mk(5'b00000, 6, 0, 0));
      chk("stall_pc", dx_pc, 32'h50);
    end
    dx_ready = 1;
    #1;
    chk("unstall_ready", fd_ready, 1);
    tick();
    chk("unstall_insn", dx_insn, mk(5'b00000, 7, 1, 2));
    chk("unstall_opA", dx_opA, 32'hAA);
    chk("unstall_opB", dx_opB, 7);

    // Flush with a pending load
    present(mk(5'b01000, 4, 1, 0), 32'h58);
    tick();
    present(mk(5'b00000, 5, 4, 4), 32'h5C);
    flush = 1;
    #1;
    chk("flush_ready", fd_ready, 0);
    tick();
    flush = 0;
    chk("flush_valid", dx_valid, 0);
    #1;
    chk("postflush_ready", fd_ready, 1);
    tick();
    chk("postflush_valid", dx_valid, 1);
    chk("postflush_insn", dx_insn, mk(5'b00000, 5, 4, 4));

    // Reset during a load-use stall
    present(mk(5'b01000, 4, 1, 0), 32'h60);
    tick();
    dx_ready = 0;
    present(mk(5'b00000, 5, 4, 4), 32'h64);
    #1;
    chk("rst_stall_ready", fd_ready, 0);
    tick();
    chk("rst_held_valid", dx_valid, 1);
    ctrl_reset = 1;
    tick();
    ctrl_reset = 0;
    chk("rst_valid", dx_valid, 0);
    chk("rst_insn", dx_insn, 0);
    chk("rst_pc", dx_pc, 0);
    chk("rst_opA", dx_opA, 0);
    chk("rst_opB", dx_opB, 0);
    dx_ready = 1;
    #1;
    chk("rst_reissue_ready", fd_ready, 1);
    present(mk(5'b00000, 1, 0, 0), 32'h68);
    wb_we = 1; wb_reg = 0; wb_data = 32'hFF;
    #1;
    chk("wb0_ready", fd_ready, 1);
    tick();
    wb_we = 0;
    chk("wb0_valid", dx_valid, 1);
    chk("wb0_opA", dx_opA, 0);
    chk("wb0_opB", dx_opB, 0);
    fd_valid = 0;
    tick();

    // Combinational decode/ready vectors from an idle stage
    vt[0]  = '{1'b1, mk(5'b00000, 3, 1, 2), 1'b0, 5'd0,  5'd1,  5'd2,  1'b1, 1'b1};
    vt[1]  = '{1'b1, mk(5'b00101, 3, 5, 0), 1'b0, 5'd0,  5'd5,  5'd0,  1'b1, 1'b1};
    vt[2]  = '{1'b1, mk(5'b00111, 9, 5, 0), 1'b0, 5'd0,  5'd5,  5'd9,  1'b1, 1'b1};
    vt[3]  = '{1'b1, mk(5'b00010, 2, 3, 0), 1'b0, 5'd0,  5'd3,  5'd2,  1'b1, 1'b1};
    vt[4]  = '{1'b1, mk(5'b00110, 6, 7, 0), 1'b0, 5'd0,  5'd7,  5'd6,  1'b1, 1'b1};
    vt[5]  = '{1'b1, mk(5'b00100, 31, 0, 0), 1'b0, 5'd0, 5'd0,  5'd31, 1'b1, 1'b1};
    vt[6]  = '{1'b1, mk(5'b10110, 0, 5, 0), 1'b0, 5'd0,  5'd30, 5'd0,  1'b1, 1'b1};
    vt[7]  = '{1'b1, mk(5'b10101, 0, 9, 0), 1'b0, 5'd0,  5'd9,  5'd0,  1'b1, 1'b1};
    vt[8]  = '{1'b1, mk(5'b01000, 4, 1, 0), 1'b0, 5'd0,  5'd1,  5'd0,  1'b1, 1'b1};
    vt[9]  = '{1'b1, mk(5'b00000, 3, 1, 2), 1'b1, 5'd2,  5'd1,  5'd2,  1'b1, 1'b0};
    vt[10] = '{1'b1, mk(5'b00000, 0, 0, 0), 1'b1, 5'd0,  5'd0,  5'd0,  1'b1, 1'b1};
    vt[11] = '{1'b1, mk(5'b00101, 6, 5, 0), 1'b1, 5'd6,  5'd5,  5'd0,  1'b1, 1'b1};
    vt[12] = '{1'b0, mk(5'b00000, 3, 1, 2), 1'b0, 5'd0,  5'd1,  5'd2,  1'b0, 1'b0};
    vt[13] = '{1'b1, mk(5'b10110, 0, 5, 0), 1'b1, 5'd30, 5'd30, 5'd0,  1'b1, 1'b0};
    vt[14] = '{1'b1, mk(5'b00000, 3, 1, 2), 1'b0, 5'd1,  5'd1,  5'd2,  1'b1, 1'b1};
    for (int v = 0; v < 15; v++) begin
      fd_valid = vt[v].fv; fd_insn = vt[v].insn; fd_pc = 32'h1000 + 32'(v);
      wb_we = vt[v].we; wb_reg = vt[v].wreg; wb_data = 32'hBEEF;
      #1;
`ifdef DX_WB_BYPASS_EN
      exp_rdy = vt[v].rdy_byp;
`else
      exp_rdy = vt[v].rdy_nob;
`endif
      chk($sformatf("vec%0d_rdA", v), ctrl_readRegA, vt[v].ea);
      chk($sformatf("vec%0d_rdB", v), ctrl_readRegB, vt[v].eb);
      chk($sformatf("vec%0d_ready", v), fd_ready, exp_rdy);
      fd_valid = 0; wb_we = 0;
      tick();
    end

    // Randomised traffic against the reference model
    ops = '{5'b00000, 5'b00101, 5'b00111, 5'b01000, 5'b00010,
            5'b00110, 5'b00100, 5'b10110, 5'b10101, 5'b00001};
    for (int c = 0; c < 400; c++) begin
      chk("rnd_valid", dx_valid, m_valid);
      if (m_valid) begin
        chk("rnd_insn", dx_insn, m_insn);
        chk("rnd_pc", dx_pc, m_pc);
        chk("rnd_opA", dx_opA, m_opA);
        chk("rnd_opB", dx_opB, m_opB);
      end
      ctrl_reset = ($urandom_range(0, 59) == 0);
      flush      = ($urandom_range(0, 11) == 0);
      fd_valid   = ($urandom_range(0, 3) != 0);
      dx_ready   = ($urandom_range(0, 3) != 0);
      op = ops[$urandom_range(0, 9)];
      rd = 5'($urandom_range(0, 7));
      rs = 5'($urandom_range(0, 7));
      rt = 5'($urandom_range(0, 7));
      fd_insn = {op, rd, rs, rt, 12'($urandom)};
      fd_pc   = $urandom;
      wb_we   = ($urandom_range(0, 2) == 0);
      wb_reg  = 5'($urandom_range(0, 7));
      wb_data = $urandom;
      #4;
      chk("rnd_ready", fd_ready, m_ready());
      chk("rnd_rdA", ctrl_readRegA, m_addr_a(fd_insn));
      chk("rnd_rdB", ctrl_readRegB, m_addr_b(fd_insn));
      @(posedge clock);
      #1;
    end
    chk("rnd_final_valid", dx_valid, m_valid);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dx_operand_stage.md
# dx_operand_stage

Decode-to-execute operand stage of the 5-stage CPU. It decodes the instruction held in the F/D latch into the register file's two read addresses and captures the returned operands into the D/X pipeline register. It forwards same-cycle writeback data past the register file, inserts a bubble on load-use hazards, and runs a valid/ready handshake to execute.

## Interface
- No parameters; widths fixed at 32-bit data, 5-bit register index.
- clock  in  1  single clock; all state updates on rising edge
- ctrl_reset  in  1  synchronous, active-high reset
- flush  in  1  kill D/X contents (branch/jump redirect)
- fd_valid  in  1  F/D latch holds an instruction
- fd_ready  out  1  instruction accepted this cycle
- fd_insn, fd_pc  in  32 each  instruction and its PC
- ctrl_readRegA, ctrl_readRegB  out  5 each  register file read addresses (combinational)
- data_readRegA, data_readRegB  in  32 each  register file read data (combinational)
- wb_we, wb_reg, wb_data  in  1/5/32  writeback port; same signals drive the register file write port
- dx_valid  out  1  D/X register holds an instruction
- dx_ready  in  1  execute consumes D/X this cycle
- dx_insn, dx_pc, dx_opA, dx_opB  out  32 each  registered instruction, PC, operands

## Operation
- Fields: opcode [31:27], rd [26:22], rs [21:17], rt [16:12].
- Port A reads rs, or r30 for bex (10110).
- Port B reads rt for R-type (00000); rd for sw (00111), bne (00010), blt (00110), jr (00100); 0 otherwise.
- Reads of r0 yield 0. Reads of r0 never bypass and never hazard.
- Write-through bypass: if wb_we, wb_reg≠0, and wb_reg equals a read address, wb_data replaces that port's data.
- Load-use tracking: `ld_pend`/`ld_reg` are set when an lw (01000) with rd≠0 moves into D/X.
  - A hazard exists when `ld_pend` is set and either used read address equals `ld_reg`.
  - Unused port B (address 0) never matches.
- Advance condition: `adv = !dx_valid || dx_ready`.
- fd_ready = fd_valid && adv && !hazard && !flush.
- When adv is true:
  - If fd_ready, D/X loads fd_insn, fd_pc and the (bypassed) operands, and dx_valid becomes 1.
  - Otherwise dx_valid becomes 0 (bubble).
  - `ld_pend` is cleared whenever D/X advances, then set again if the loaded instruction is lw.
- When adv is false: all D/X outputs and `ld_pend` hold.
- flush: dx_valid←0 and ld_pend←0 next cycle; no instruction is accepted that cycle. flush overrides ready, hazard and hold.
- ctrl_reset has priority over flush.

## Timing
- Reset values: dx_valid=0; dx_insn, dx_pc, dx_opA, dx_opB = 0; ld_pend=0.
- fd_ready, ctrl_readRegA and ctrl_readRegB are combinational from the inputs.
- Latency: an instruction accepted at edge N is visible on the D/X outputs after edge N.
- A load-use hazard costs exactly one bubble cycle when execute is not stalling. During an execute stall, the hazard simply persists until D/X advances.
- Reset mid-stall drops the held instruction; F/D reissues it.

## Configuration
- `DX_WB_BYPASS_EN` defined: write-through bypass as above.
- Undefined: no bypass path. A read-address match against an active writeback (wb_we, wb_reg≠0) counts as a hazard: fd_ready=0 for that cycle. The instruction is re-read the following cycle, after the register file has been written.

## Structure
- Shared package `cpu_isa_pkg`: opcode constants (OP_RTYPE, OP_ADDI, OP_SW, OP_LW, OP_BNE, OP_BLT, OP_JR, OP_BEX, OP_SETX), field bit-position constants, register index width, and REG_STATUS=30.
- Sub-module `dx_read_decode`: purely combinational; maps insn to the two read addresses and the port-used flags.
- The top module holds the bypass muxes, hazard logic, ld_pend/ld_reg, and the D/X register.

## Test plan
- add r3,r1,r2 with r1=5, r2=7, dx_ready=1 -> next cycle dx_valid=1, dx_opA=5, dx_opB=7; fd_ready=1 throughout.
- wb_we=1, wb_reg=1, wb_data=0xAA in the same cycle add r3,r1,r2 is decoded:
  - with the macro -> dx_opA=0xAA, no stall;
  - without the macro -> one cycle fd_ready=0, then dx_opA=0xAA.
- lw r4,0(r1) followed by add r5,r4,r4 -> one cycle with dx_valid=0, then the add is latched; a following add r6,r0,r0 gets no bubble.
- dx_ready=0 for 3 cycles with dx_valid=1 -> D/X outputs stable, fd_ready=0; the queued instruction is latched on the first dx_ready=1 edge.
- flush asserted with dx_valid=1 and ld_pend=1 -> next cycle dx_valid=0, a dependent add is accepted without a bubble.
- ctrl_reset=1 during a load-use stall -> next cycle all outputs 0, dx_valid=0; wb_reg=0 with wb_data=0xFF never changes a read of r0 (stays 0).
